// File: rtl/jtpang_colmix_nl_if.sv
// Pixel, blanking, CPU palette and colour-output signals of the N-layer colour mixer.
// master = pixel generators / CPU / video sink, slave = the mixer.
interface jtpang_colmix_nl_if #(
  parameter int LAYERS = 2,
  parameter int PXLW   = 11,
  parameter int CW     = 4,
  parameter int BKW    = 1
);
  localparam int NB   = (3*CW+7)/8;
  localparam int SELW = (NB > 1) ? $clog2(NB) : 1;

  logic                   pxl_cen;
  logic                   LHBL;
  logic                   LVBL;
  logic                   video_enb;
  logic [LAYERS*PXLW-1:0] lyr_pxl;
  logic [BKW-1:0]         pal_bank;
  logic                   pal_cs;
  logic                   wr_n;
  logic [PXLW+SELW-1:0]   cpu_addr;
  logic [7:0]             cpu_dout;
  logic [7:0]             pal_dout;
  logic [CW-1:0]          red;
  logic [CW-1:0]          green;
  logic [CW-1:0]          blue;
  logic                   ovr;

  modport master (
    output pxl_cen, LHBL, LVBL, video_enb, lyr_pxl, pal_bank, pal_cs, wr_n, cpu_addr, cpu_dout,
    input  pal_dout, red, green, blue, ovr
  );

  modport slave (
    input  pxl_cen, LHBL, LVBL, video_enb, lyr_pxl, pal_bank, pal_cs, wr_n, cpu_addr, cpu_dout,
    output pal_dout, red, green, blue, ovr
  );
endinterface

// File: rtl/jtpang_colmix_nl.sv
// N-layer colour mixer: priority pick of the first opaque layer, then a byte-wise fetch of its
// RGB entry from a banked CPU-writable palette. Output lags the layer pixels by one pixel period.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no pixel latched since reset
//   ST_FETCH | palette byte bsel_q is being addressed
//   ST_WAIT  | last byte in flight from the RAM
//   ST_DONE  | pending colour complete, waiting for next pxl_cen
module jtpang_colmix_nl #(
  parameter int LAYERS = 2,
  parameter int PXLW   = 11,
  parameter int TRW    = 4,
  parameter int CW     = 4,
  parameter int BKW    = 1
) (
  input logic              clk,
  input logic              rst_n,
  jtpang_colmix_nl_if.slave mix_if
);
  localparam int NB    = (3*CW+7)/8;
  localparam int SELW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW    = PXLW + BKW + SELW;
  localparam int SELN  = 1 << SELW;
  localparam int CBITS = 3*CW;
  localparam logic [SELN-1:0] SEL_OK = SELN'((64'd1 << NB) - 64'd1);
  localparam logic [SELW-1:0] LAST   = SELW'(NB-1);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_WAIT, ST_DONE} state_t;

  logic [7:0]       pal_mem [0:(1<<AW)-1];
  logic [7:0]       pal_dout_q;
  logic [7:0]       vdata_q;
  state_t           state_q;
  logic [SELW-1:0]  bsel_q;
  logic [SELW-1:0]  cap_sel_q;
  logic             cap_vld_q;
  logic [PXLW-1:0]  idx_q;
  logic [CBITS-1:0] pend_q;
  logic [CBITS-1:0] pend_d;
  logic [CBITS-1:0] rgb_q;
  logic             ovr_q;

  logic [PXLW-1:0]  sel_pxl;
  logic [SELW-1:0]  cpu_sel;
  logic             cpu_ok;
  logic [AW-1:0]    cpu_a;
  logic [AW-1:0]    vid_a;
  logic             blank;

  // Walk from the background layer up so the lowest opaque layer wins.
  always_comb begin
    sel_pxl = mix_if.lyr_pxl[(LAYERS-1)*PXLW +: PXLW];
    for (int k = LAYERS-1; k >= 0; k--) begin
      if (mix_if.lyr_pxl[k*PXLW +: TRW] != {TRW{1'b1}})
        sel_pxl = mix_if.lyr_pxl[k*PXLW +: PXLW];
    end
  end

  assign cpu_sel = mix_if.cpu_addr[SELW-1:0];
  assign cpu_ok  = SEL_OK[cpu_sel];
  assign cpu_a   = {cpu_sel, mix_if.pal_bank, mix_if.cpu_addr[SELW +: PXLW]};
  assign vid_a   = {bsel_q, mix_if.pal_bank, idx_q};
  assign blank   = !mix_if.LHBL || !mix_if.LVBL || mix_if.video_enb;

  always_ff @(posedge clk) begin
    if (mix_if.pal_cs && !mix_if.wr_n && cpu_ok)
      pal_mem[cpu_a] <= mix_if.cpu_dout;
    pal_dout_q <= cpu_ok ? pal_mem[cpu_a] : 8'h00;
    vdata_q    <= pal_mem[vid_a];
  end

  always_comb begin
    pend_d = pend_q;
    if (cap_vld_q) begin
      for (int i = 0; i < CBITS; i++) begin
        if ((i / 8) == int'(cap_sel_q))
          pend_d[i] = vdata_q[3'(i % 8)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bsel_q    <= '0;
      cap_sel_q <= '0;
      cap_vld_q <= 1'b0;
      idx_q     <= '0;
      pend_q    <= '0;
      rgb_q     <= '0;
      ovr_q     <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      cap_vld_q <= 1'b0;
      cap_sel_q <= bsel_q;
      if (mix_if.pxl_cen) begin
        // A new pixel aborts any fetch in flight; its late byte is dropped.
        idx_q   <= sel_pxl;
        bsel_q  <= '0;
        state_q <= ST_FETCH;
        if (state_q == ST_FETCH || state_q == ST_WAIT)
          ovr_q <= 1'b1;
      end else begin
        case (state_q)
          ST_FETCH: begin
            cap_vld_q <= 1'b1;
            if (bsel_q == LAST)
              state_q <= ST_WAIT;
            else
              bsel_q <= bsel_q + SELW'(1);
          end
          ST_WAIT: state_q <= ST_DONE;
          default: state_q <= state_q;
        endcase
      end
      if (blank)
        rgb_q <= '0;
      else if (mix_if.pxl_cen)
        rgb_q <= pend_q;
    end
  end

  assign mix_if.red      = rgb_q[3*CW-1 -: CW];
  assign mix_if.green    = rgb_q[2*CW-1 -: CW];
  assign mix_if.blue     = rgb_q[CW-1 -: CW];
  assign mix_if.pal_dout = pal_dout_q;
  assign mix_if.ovr      = ovr_q;
endmodule

// File: tb/tb_jtpang_colmix_nl.sv
// Directed bench for the colour mixer: one 12-bit (CW=4) and one 24-bit (CW=8) instance
// sharing clock and reset, checked against hand-computed palette colours.
module tb_jtpang_colmix_nl;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  jtpang_colmix_nl_if #(.LAYERS(2), .PXLW(11), .CW(4), .BKW(1)) if4 ();
  jtpang_colmix_nl_if #(.LAYERS(2), .PXLW(11), .CW(8), .BKW(1)) if8 ();

  jtpang_colmix_nl #(.LAYERS(2), .PXLW(11), .TRW(4), .CW(4), .BKW(1)) u_dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .mix_if (if4)
  );

  jtpang_colmix_nl #(.LAYERS(2), .PXLW(11), .TRW(4), .CW(8), .BKW(1)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .mix_if (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One pixel on both mixers, period 6 clks (covers NB+2 for the 24-bit instance).
  task automatic pix();
    if4.pxl_cen = 1'b1;
    if8.pxl_cen = 1'b1;
    tick();
    if4.pxl_cen = 1'b0;
    if8.pxl_cen = 1'b0;
    tick(5);
  endtask

  task automatic pulse4(input int period);
    if4.pxl_cen = 1'b1;
    tick();
    if4.pxl_cen = 1'b0;
    tick(period - 1);
  endtask

  task automatic wr4(input logic [11:0] a, input logic [7:0] d);
    if4.cpu_addr = a;
    if4.cpu_dout = d;
    if4.pal_cs   = 1'b1;
    if4.wr_n     = 1'b0;
    tick();
    if4.pal_cs   = 1'b0;
    if4.wr_n     = 1'b1;
  endtask

  task automatic wr8(input logic [12:0] a, input logic [7:0] d);
    if8.cpu_addr = a;
    if8.cpu_dout = d;
    if8.pal_cs   = 1'b1;
    if8.wr_n     = 1'b0;
    tick();
    if8.pal_cs   = 1'b0;
    if8.wr_n     = 1'b1;
  endtask

  task automatic rd4(input string tag, input logic [11:0] a, input logic [7:0] exp);
    if4.cpu_addr = a;
    tick();
    chk(tag, {24'h0, if4.pal_dout}, {24'h0, exp});
  endtask

  task automatic rd8(input string tag, input logic [12:0] a, input logic [7:0] exp);
    if8.cpu_addr = a;
    tick();
    chk(tag, {24'h0, if8.pal_dout}, {24'h0, exp});
  endtask

  function automatic logic [31:0] rgb4();
    return {20'h0, if4.red, if4.green, if4.blue};
  endfunction

  function automatic logic [31:0] rgb8();
    return {8'h0, if8.red, if8.green, if8.blue};
  endfunction

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    if4.pxl_cen = 1'b0; if4.LHBL = 1'b1; if4.LVBL = 1'b1; if4.video_enb = 1'b0;
    if4.lyr_pxl = '1;   if4.pal_bank = '0; if4.pal_cs = 1'b0; if4.wr_n = 1'b1;
    if4.cpu_addr = '0;  if4.cpu_dout = '0;
    if8.pxl_cen = 1'b0; if8.LHBL = 1'b1; if8.LVBL = 1'b1; if8.video_enb = 1'b0;
    if8.lyr_pxl = '1;   if8.pal_bank = '0; if8.pal_cs = 1'b0; if8.wr_n = 1'b1;
    if8.cpu_addr = '0;  if8.cpu_dout = '0;

    tick(3);
    chk("reset_rgb4", rgb4(), 32'h0);
    chk("reset_ovr4", {31'h0, if4.ovr}, 32'h0);
    chk("reset_rgb8", rgb8(), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // 12-bit palette: idx 0x005 = A3C, idx 0x123 = 123, idx 0x12F = 455
    wr4({11'h005, 1'b0}, 8'h3C);
    wr4({11'h005, 1'b1}, 8'h0A);
    wr4({11'h123, 1'b0}, 8'h23);
    wr4({11'h123, 1'b1}, 8'h01);
    wr4({11'h12F, 1'b0}, 8'h55);
    wr4({11'h12F, 1'b1}, 8'h04);
    rd4("rd4_idx5_b0", {11'h005, 1'b0}, 8'h3C);
    rd4("rd4_idx5_b1", {11'h005, 1'b1}, 8'h0A);

    if4.lyr_pxl = {11'h123, 11'h005};
    pix();
    chk("lat_first_pix", rgb4(), 32'h0);
    pix();
    chk("layer0_opaque", rgb4(), 32'hA3C);

    if4.lyr_pxl = {11'h123, 11'h00F};
    pix();
    chk("one_pix_latency", rgb4(), 32'hA3C);
    pix();
    chk("layer0_transp", rgb4(), 32'h123);

    if4.lyr_pxl = {11'h12F, 11'h0FF};
    pix();
    pix();
    chk("all_transp_bg", rgb4(), 32'h455);

    // 24-bit palette: three bytes per entry, byte select 3 does not exist
    wr8({11'h010, 2'd0}, 8'h11);
    wr8({11'h010, 2'd1}, 8'h22);
    wr8({11'h010, 2'd2}, 8'h33);
    wr8({11'h010, 2'd3}, 8'hEE);
    rd8("rd8_b2", {11'h010, 2'd2}, 8'h33);
    rd8("rd8_b3_ignored", {11'h010, 2'd3}, 8'h00);
    if8.lyr_pxl = {11'h7FF, 11'h010};
    pix();
    pix();
    chk("rgb24", rgb8(), 32'h332211);

    // banked palette
    if4.pal_bank = 1'b1;
    wr4({11'h005, 1'b0}, 8'h99);
    rd4("bank1_rd", {11'h005, 1'b0}, 8'h99);
    if4.pal_bank = 1'b0;
    rd4("bank0_kept", {11'h005, 1'b0}, 8'h3C);

    // blanking
    if4.lyr_pxl = {11'h123, 11'h005};
    pix();
    pix();
    chk("pre_blank", rgb4(), 32'hA3C);
    if4.LHBL = 1'b0;
    tick();
    chk("hblank_black", rgb4(), 32'h0);
    if4.lyr_pxl = {11'h7FF, 11'h123};
    pix();
    chk("hblank_pix_black", rgb4(), 32'h0);
    if4.LHBL = 1'b1;
    pix();
    chk("after_hblank", rgb4(), 32'h123);
    if4.video_enb = 1'b1;
    tick();
    chk("venb_black", rgb4(), 32'h0);
    if4.lyr_pxl = {11'h123, 11'h005};
    pix();
    if4.video_enb = 1'b0;
    pix();
    chk("after_venb", rgb4(), 32'hA3C);

    // overrun: period NB+2 is legal, period 2 is not
    repeat (3) pulse4(4);
    chk("ovr_min_period", {31'h0, if4.ovr}, 32'h0);
    repeat (4) pulse4(2);
    chk("ovr_set", {31'h0, if4.ovr}, 32'h1);
    tick(8);
    chk("ovr_sticky", {31'h0, if4.ovr}, 32'h1);
    chk("ovr8_clear", {31'h0, if8.ovr}, 32'h0);

    // asynchronous reset mid-operation; palette survives
    if4.pxl_cen = 1'b1;
    tick();
    if4.pxl_cen = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ovr", {31'h0, if4.ovr}, 32'h0);
    chk("async_rst_rgb", rgb4(), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ovr", {31'h0, if4.ovr}, 32'h0);
    rd4("ram_kept", {11'h005, 1'b1}, 8'h0A);
    pix();
    pix();
    chk("post_rst_pix", rgb4(), 32'hA3C);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
